imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: resetn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: in_valid  input  1  request present.
REQ-004 SHALL have port: in_ready  output  1  request accepted when in_valid && in_ready at a clk edge.
REQ-005 SHALL have port: in_imm_src  input  2  format: 00 I, 01 S, 10 B, 11 J.
REQ-006 SHALL have port: in_imm  input  32  signed byte-offset or immediate value to encode.
REQ-007 SHALL have port: in_base  input  32  instruction word; immediate bit positions ignored and overwritten.
REQ-008 SHALL have port: out_valid  output  1  encoded word present.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts when out_valid && out_ready.
REQ-010 SHALL have port: out_instr  output  32  encoded instruction.
REQ-011 SHALL have port: out_err  output  1  immediate not representable in the selected format.
REQ-012 SHALL have port: err_count  output  16  saturating count of errored words delivered.

Function
REQ-013 SHALL place bits as follows; non-immediate bits are taken from in_base:
- I: instr[31:20]=imm[11:0].
- S: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0].
- B: instr[31]=imm[12], instr[7]=imm[11], instr[30:25]=imm[10:5], instr[11:8]=imm[4:1].
- J: instr[31]=imm[20], instr[19:12]=imm[19:12], instr[20]=imm[11], instr[30:21]=imm[10:1].
REQ-014 SHALL raise the error flag when in_imm differs from its sign-extension from bit 11 (I/S), bit 12 (B) or bit 20 (J), or when imm[0]=1 for B/J.
REQ-015 SHALL still emit the truncated encoding when the error flag is set; errored words are never dropped.
REQ-016 SHALL use a two-stage pipeline:
- S1 registers the encoded word and error flag.
- S2 is the output register driving out_*.
REQ-017 SHALL have a latency of exactly 2 cycles from input handshake to out_valid when there is no stall, and a throughput of 1 word/cycle.
REQ-018 SHALL advance S2 when !s2_valid || out_ready; S1 SHALL advance when !s1_valid || S2 advances; in_ready SHALL equal the S1-advance condition.
REQ-019 SHALL hold out_instr/out_err stable while out_valid && !out_ready.
REQ-020 SHALL preserve order; no word is lost or duplicated under any out_ready pattern.
REQ-021 SHALL increment err_count on each output handshake with out_err=1, saturating at 0xFFFF.
REQ-022 SHALL guarantee round trip: for in-range imm, sign-extending the re-extracted immediate of out_instr yields in_imm.

Reset
REQ-023 SHALL, while resetn=0, force out_valid=0, out_instr=0, out_err=0, err_count=0 and clear both stage valids, independent of clk.
REQ-024 SHALL discard in-flight words on reset assertion mid-operation; in_ready SHALL be 1 in the first cycle after release.

Structure
REQ-025 SHALL take the format codes IMM_I/IMM_S/IMM_B/IMM_J from the shared core package, the same definitions used by the immediate extender.
REQ-026 SHALL isolate packing and range check in one combinational sub-module, imm_pack; the pipeline and counter live in imm_encoder.

Verification
REQ-027 I: base=0x00000013, imm=0xFFFFFFFF, src=00 -> out_instr=0xFFF00013, err=0, out_valid 2 cycles after accept.
REQ-028 S: base=0x00002023, imm=0xFFFFF800, src=01 -> 0x80002023, err=0; B: base=0x00000063, imm=0x00000800, src=10 -> 0x000000E3, err=0.
REQ-029 Errors: I imm=2048 -> err=1, instr[31:20]=0x800; J imm=3 -> err=1; err_count reads 2 after both are delivered.
REQ-030 Backpressure: out_ready=0 while 3 words are offered -> 2 are accepted, in_ready=0 on the 3rd; after out_ready=1 all 3 exit in order.
REQ-031 Reset with both stages valid -> out_valid=0 and err_count=0 asynchronously; no stale word after release.
REQ-032 Random round trip: 10k random in-range imm/src -> decoded immediate equals input and err=0.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared core definitions for immediate formats: the format codes used by both
// the immediate extender and the immediate encoder, plus a range-check helper.
package imm_encoder_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  // Sign-bit position of each format's immediate field.
  localparam int unsigned SIGN_BIT_IS = 11;
  localparam int unsigned SIGN_BIT_B  = 12;
  localparam int unsigned SIGN_BIT_J  = 20;

  // True when every bit above msb replicates bit msb, i.e. v equals its
  // sign-extension from msb.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned msb);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i > msb && v[i] != v[msb]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate packer: scatters the immediate into the instruction
// word for the selected format and flags values the format cannot represent.
module imm_pack
  import imm_encoder_pkg::*;
(
  input  imm_src_e    src_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] base_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  always_comb begin
    instr_o = base_i;
    err_o   = 1'b0;
    case (src_i)
      IMM_I: begin
        instr_o[31:20] = imm_i[11:0];
        err_o          = !fits_signed(imm_i, SIGN_BIT_IS);
      end
      IMM_S: begin
        instr_o[31:25] = imm_i[11:5];
        instr_o[11:7]  = imm_i[4:0];
        err_o          = !fits_signed(imm_i, SIGN_BIT_IS);
      end
      IMM_B: begin
        instr_o[31]    = imm_i[12];
        instr_o[7]     = imm_i[11];
        instr_o[30:25] = imm_i[10:5];
        instr_o[11:8]  = imm_i[4:1];
        err_o          = !fits_signed(imm_i, SIGN_BIT_B) || imm_i[0];
      end
      IMM_J: begin
        instr_o[31]    = imm_i[20];
        instr_o[19:12] = imm_i[19:12];
        instr_o[20]    = imm_i[11];
        instr_o[30:21] = imm_i[10:1];
        err_o          = !fits_signed(imm_i, SIGN_BIT_J) || imm_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready pipeline around imm_pack, with a saturating count of
// errored words handed to the consumer.
module imm_encoder
  import imm_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_imm_src,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_base,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] err_count
);

  logic [31:0] pack_instr;
  logic        pack_err;

  logic        s1_valid_q, s2_valid_q;
  logic [31:0] s1_instr_q, s2_instr_q;
  logic        s1_err_q,   s2_err_q;
  logic [15:0] err_cnt_q,  err_cnt_d;
  logic        s1_adv, s2_adv;

  imm_pack u_pack (
    .src_i   (imm_src_e'(in_imm_src)),
    .imm_i   (in_imm),
    .base_i  (in_base),
    .instr_o (pack_instr),
    .err_o   (pack_err)
  );

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (s2_valid_q && out_ready && s2_err_q && err_cnt_q != '1)
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid_q <= 1'b0;
      s1_instr_q <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_err_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_q <= in_valid;
        s1_instr_q <= pack_instr;
        s1_err_q   <= pack_err;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        s2_instr_q <= s1_instr_q;
        s2_err_q   <= s1_err_q;
      end
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_err   = s2_err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: driver pushes expected words on accept,
// negedge monitor pops and compares on every output handshake.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_imm_src;
  logic [31:0] in_imm;
  logic [31:0] in_base;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] err_count;

  imm_encoder dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_imm_src (in_imm_src),
    .in_imm     (in_imm),
    .in_base    (in_base),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_err    (out_err),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic        rt;
    logic [1:0]  src;
    logic [31:0] imm;
  } exp_t;

  exp_t        exp_q[$];
  int          vectors    = 0;
  int          miscompares = 0;
  int          err_model  = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_instr = '0;
  logic        prev_err   = 1'b0;
  bit          rnd_run;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Instruction bit p carries immediate bit src_bit(fmt,p), or -1 for a base bit.
  function automatic int src_bit(input logic [1:0] fmt, input int p);
    case (fmt)
      2'd0: if (p >= 20) return p - 20;
      2'd1: begin
        if (p >= 25) return p - 20;
        if (p >= 7 && p <= 11) return p - 7;
      end
      2'd2: begin
        if (p == 31) return 12;
        if (p == 7) return 11;
        if (p >= 25) return p - 20;
        if (p >= 8 && p <= 11) return p - 7;
      end
      default: begin
        if (p == 31) return 20;
        if (p == 20) return 11;
        if (p >= 21) return p - 20;
        if (p >= 12 && p <= 19) return p;
      end
    endcase
    return -1;
  endfunction

  function automatic int fmt_width(input logic [1:0] fmt);
    return (fmt == 2'd2) ? 13 : (fmt == 2'd3) ? 21 : 12;
  endfunction

  function automatic exp_t model(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base);
    exp_t e;
    int   w, v, b;
    w = fmt_width(src);
    v = $signed(imm);
    e.instr = base;
    for (int p = 0; p < 32; p++) begin
      b = src_bit(src, p);
      if (b >= 0) e.instr[p] = imm[b];
    end
    e.err = (v < -(1 << (w - 1))) || (v > (1 << (w - 1)) - 1) || (src >= 2'd2 && imm[0]);
    e.rt  = !e.err;
    e.src = src;
    e.imm = imm;
    return e;
  endfunction

  function automatic exp_t mk(input logic [31:0] instr, input logic err);
    exp_t e;
    e = '0;
    e.instr = instr;
    e.err   = err;
    return e;
  endfunction

  function automatic logic [31:0] decode(input logic [31:0] i, input logic [1:0] src);
    case (src)
      2'd0:    return {{20{i[31]}}, i[31:20]};
      2'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      2'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (resetn === 1'b1) begin
      if (prev_stall) begin
        check("hold_instr", out_instr, prev_instr);
        check("hold_err", {31'b0, out_err}, {31'b0, prev_err});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got 0x%08h, want none", out_instr);
        end else begin
          e = exp_q.pop_front();
          check("instr", out_instr, e.instr);
          check("err", {31'b0, out_err}, {31'b0, e.err});
          if (e.err && err_model < 65535) err_model++;
          if (e.rt) check("round_trip", decode(out_instr, e.src), e.imm);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_instr = out_instr;
      prev_err   = out_err;
    end
  end

  // Call just after a posedge; returns just after the accepting posedge.
  task automatic send(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] base, input exp_t e);
    in_valid   = 1'b1;
    in_imm_src = src;
    in_imm     = imm;
    in_base    = base;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (in_ready) break;
      if (n >= 200) begin
        fail_now("send_accept");
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; exp_q.size() != 0; n++) begin
      if (n >= 1000) begin
        fail_now("drain");
        exp_q.delete();
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic offer(input logic [31:0] imm);
    @(posedge clk);
    #1;
    in_valid   = 1'b1;
    in_imm_src = 2'd0;
    in_imm     = imm;
    in_base    = 32'h0000_0013;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  src;
    logic [31:0] imm, base;
    int          v, w;

    resetn = 1'b0; in_valid = 1'b0; in_imm_src = '0; in_imm = '0; in_base = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_err_count", {16'b0, err_count}, 32'd0);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;

    // Latency on an empty pipeline: S1 in cycle 1, out_valid in cycle 2.
    send(2'd0, 32'hFFFF_FFFF, 32'h0000_0013, mk(32'hFFF0_0013, 1'b0));
    @(negedge clk);
    check("lat_cycle1_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check("lat_cycle2_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #1;

    send(2'd1, 32'hFFFF_F800, 32'h0000_2023, mk(32'h8000_2023, 1'b0));
    send(2'd2, 32'h0000_0800, 32'h0000_0063, mk(32'h0000_00E3, 1'b0));
    send(2'd0, 32'd2048,      32'h0000_0013, mk(32'h8000_0013, 1'b1));
    send(2'd3, 32'd3,         32'h0000_006F, mk(32'h0020_006F, 1'b1));
    drain();
    @(posedge clk);
    #1;
    check("err_count_two", {16'b0, err_count}, 32'd2);

    // Backpressure: two words fit, the third is refused until the consumer drains.
    out_ready = 1'b0;
    offer(32'd1);
    check("bp_ready_1", {31'b0, in_ready}, 32'd1);
    exp_q.push_back(model(2'd0, 32'd1, 32'h0000_0013));
    offer(32'd2);
    check("bp_ready_2", {31'b0, in_ready}, 32'd1);
    exp_q.push_back(model(2'd0, 32'd2, 32'h0000_0013));
    offer(32'd3);
    check("bp_ready_3", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check("bp_ready_3_held", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(2'd0, 32'd3, 32'h0000_0013, model(2'd0, 32'd3, 32'h0000_0013));
    drain();

    // Reset with both stages occupied.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(2'd0, 32'd4095, 32'h0000_0013, model(2'd0, 32'd4095, 32'h0000_0013));
    send(2'd1, 32'd5,    32'h0000_2023, model(2'd1, 32'd5, 32'h0000_2023));
    @(negedge clk);
    check("pre_rst_out_valid", {31'b0, out_valid}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_out_instr", out_instr, 32'd0);
    check("arst_out_err", {31'b0, out_err}, 32'd0);
    check("arst_err_count", {16'b0, err_count}, 32'd0);
    exp_q.delete();
    err_model  = 0;
    prev_stall = 1'b0;
    @(posedge clk);
    #2 resetn = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_stale_word", {31'b0, out_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    // Random traffic under random backpressure: in-range round trips, then arbitrary values.
    rnd_run = 1'b1;
    fork
      begin
        for (int k = 0; k < 10500; k++) begin
          src  = 2'($urandom_range(0, 3));
          base = $urandom;
          if (k < 10000) begin
            w = fmt_width(src);
            v = int'($urandom_range(0, (1 << w) - 1)) - (1 << (w - 1));
            if (src >= 2'd2) v = v & ~1;
            imm = v;
          end else begin
            imm = (k % 2 == 0) ? $urandom : {{20{1'b0}}, 12'($urandom)} - 32'd2048;
          end
          send(src, imm, base, model(src, imm, base));
        end
        rnd_run = 1'b0;
      end
      begin
        while (rnd_run) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    @(posedge clk);
    #1;
    check("err_count_random", {16'b0, err_count}, 32'(err_model));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
